bullet_pool: RTL and testbench

Parametrised multi-shot projectile controller. It tracks up to NUM_BULLETS independent bullets, each travelling straight up from the player at its own fixed rate. It adds fire-edge detection, a re-fire cooldown, a finite ammo supply and a per-slot hit interface, which enemy collision logic drives. It sits between the player position logic and the enemy and draw logic; the drawing FSM uses the packed coordinates, `active` mask and `move` pulse to erase and redraw.

---
 rtl/bullet_pool.sv | 161 ++++++++++++++++
 tb/tb_bullet_pool.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_pool.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : bullet_pool                                              |
// | Purpose : multi-slot projectile pool with fire edge detect,        |
// |           cooldown, ammo supply and per-slot hit handling          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module bullet_pool #(
   parameter int NUM_BULLETS = 4,
   parameter int RATE_DIV    = 500000,
   parameter int COOLDOWN    = 2000000,
   parameter int AMMO_MAX    = 15,
   parameter int COUNT_W     = 28
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     play,
   input  logic                     load_level,
   input  logic                     fire,
   input  logic [7:0]               playerX,
   input  logic [6:0]               playerY,
   input  logic [NUM_BULLETS-1:0]   hit,
   output logic [NUM_BULLETS-1:0]   active,
   output logic [8*NUM_BULLETS-1:0] bulletX,
   output logic [7*NUM_BULLETS-1:0] bulletY,
   output logic                     move,
   output logic [7:0]               ammo,
   output logic [7:0]               hit_count
);

   localparam logic [COUNT_W-1:0] c_rate_div = COUNT_W'(RATE_DIV);
   localparam logic [COUNT_W-1:0] c_cooldown = COUNT_W'(COOLDOWN);
   localparam logic [7:0]         c_ammo_max = 8'(AMMO_MAX);

   logic                   w_rst;
   logic                   w_launch_req;
   logic                   w_launch;
   logic [7:0]             w_park_x;
   logic [6:0]             w_park_y;
   logic [NUM_BULLETS-1:0] w_active;
   logic [NUM_BULLETS-1:0] w_free_sel;
   logic [NUM_BULLETS-1:0] w_hit_ok;
   logic [NUM_BULLETS-1:0] w_step_dec;
   logic [3:0]             w_hits_n;
   logic [8:0]             w_hit_sum;

   logic                   r_fire_q;
   logic [COUNT_W-1:0]     r_cooldown;
   logic [7:0]             r_ammo;
   logic [7:0]             r_hit_count;
   logic                   r_move;

   assign w_rst        = ~resetn | load_level;
   assign w_launch_req = fire & ~r_fire_q;
   assign w_park_x     = playerX + 8'd1;
   assign w_park_y     = playerY + 7'd1;
   assign w_hit_ok     = hit & w_active;

   // Lowest-index free slot wins; scanning downward lets the lowest overwrite.
   always_comb begin
      w_free_sel = '0;
      for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
         if (!w_active[i]) begin
            w_free_sel    = '0;
            w_free_sel[i] = 1'b1;
         end
      end
   end

   assign w_launch = w_launch_req & play & (r_cooldown == '0) &
                     (r_ammo != 8'd0) & (|w_free_sel);

   always_comb begin
      w_hits_n = '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
         w_hits_n = w_hits_n + 4'(w_hit_ok[i]);
      end
   end

   assign w_hit_sum = {1'b0, r_hit_count} + 9'(w_hits_n);

   genvar g;
   generate
      for (g = 0; g < NUM_BULLETS; g++) begin : g_slot
         logic               r_act;
         logic [COUNT_W-1:0] r_cnt;
         logic [7:0]         r_x;
         logic [6:0]         r_y;
         logic               w_tick;

         // A hit outranks the step tick landing on the same cycle.
         assign w_tick        = r_act & play & ~w_hit_ok[g] & (r_cnt == c_rate_div);
         assign w_step_dec[g] = w_tick & (r_y != 7'd0);
         assign w_active[g]   = r_act;

         always_ff @(posedge clk) begin
            if (w_rst) begin
               r_act <= 1'b0;
               r_cnt <= '0;
               r_x   <= '0;
               r_y   <= '0;
            end else if (r_act) begin
               if (w_hit_ok[g]) begin
                  r_act <= 1'b0;
                  r_cnt <= '0;
               end else if (play) begin
                  if (r_cnt != c_rate_div) begin
                     r_cnt <= r_cnt + COUNT_W'(1);
                  end else begin
                     r_cnt <= '0;
                     if (r_y == 7'd0) begin
                        r_act <= 1'b0;
                     end else begin
                        r_y <= r_y - 7'd1;
                     end
                  end
               end
            end else if (w_launch && w_free_sel[g]) begin
               r_act <= 1'b1;
               r_cnt <= '0;
               r_x   <= w_park_x;
               r_y   <= playerY;
            end else begin
               r_x <= w_park_x;
               r_y <= w_park_y;
            end
         end

         assign bulletX[8*g +: 8] = r_x;
         assign bulletY[7*g +: 7] = r_y;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_fire_q    <= 1'b0;
         r_cooldown  <= '0;
         r_ammo      <= c_ammo_max;
         r_hit_count <= '0;
         r_move      <= 1'b0;
      end else begin
         r_fire_q <= fire;
         r_move   <= |w_step_dec;
         if (w_launch) begin
            r_ammo     <= r_ammo - 8'd1;
            r_cooldown <= c_cooldown;
         end else if (play && (r_cooldown != '0)) begin
            r_cooldown <= r_cooldown - COUNT_W'(1);
         end
         r_hit_count <= w_hit_sum[8] ? 8'hFF : w_hit_sum[7:0];
      end
   end

   assign active    = w_active;
   assign move      = r_move;
   assign ammo      = r_ammo;
   assign hit_count = r_hit_count;

endmodule
`default_nettype wire

// File: tb/tb_bullet_pool.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_bullet_pool                                           |
// | Purpose : directed self-checking bench for bullet_pool             |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_bullet_pool;

   localparam int NB = 2;

   logic          clk;
   logic          resetn;
   logic          play;
   logic          load_level;
   logic          fire;
   logic [7:0]    playerX;
   logic [6:0]    playerY;
   logic [NB-1:0] hit;
   logic [NB-1:0] active;
   logic [8*NB-1:0] bulletX;
   logic [7*NB-1:0] bulletY;
   logic          move;
   logic [7:0]    ammo;
   logic [7:0]    hit_count;

   int n_vec;
   int n_err;

   bullet_pool #(
      .NUM_BULLETS(NB),
      .RATE_DIV   (3),
      .COOLDOWN   (5),
      .AMMO_MAX   (3),
      .COUNT_W    (8)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .play      (play),
      .load_level(load_level),
      .fire      (fire),
      .playerX   (playerX),
      .playerY   (playerY),
      .hit       (hit),
      .active    (active),
      .bulletX   (bulletX),
      .bulletY   (bulletY),
      .move      (move),
      .ammo      (ammo),
      .hit_count (hit_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      resetn = 1'b0; play = 1'b0; load_level = 1'b0; fire = 1'b0;
      playerX = 8'd80; playerY = 7'd115; hit = '0;

      // Reset and launch
      step(2);
      chk("rst_active", 32'(active), 32'd0);
      chk("rst_ammo", 32'(ammo), 32'd3);
      chk("rst_hits", 32'(hit_count), 32'd0);
      chk("rst_move", 32'(move), 32'd0);
      chk("rst_x0", 32'(bulletX[7:0]), 32'd0);
      chk("rst_y0", 32'(bulletY[6:0]), 32'd0);
      resetn = 1'b1; play = 1'b1;
      step(1);
      chk("park_x0", 32'(bulletX[7:0]), 32'd81);
      chk("park_y0", 32'(bulletY[6:0]), 32'd116);
      fire = 1'b1;
      step(1);
      chk("launch_active", 32'(active), 32'b01);
      chk("launch_x0", 32'(bulletX[7:0]), 32'd81);
      chk("launch_y0", 32'(bulletY[6:0]), 32'd115);
      chk("launch_ammo", 32'(ammo), 32'd2);
      chk("launch_y1_parked", 32'(bulletY[13:7]), 32'd116);
      step(3);
      chk("pre_step_y0", 32'(bulletY[6:0]), 32'd115);
      chk("pre_step_move", 32'(move), 32'd0);
      step(1);
      chk("step_y0", 32'(bulletY[6:0]), 32'd114);
      chk("step_move", 32'(move), 32'd1);
      step(1);
      chk("move_one_cycle", 32'(move), 32'd0);
      // fire still held: no auto-repeat
      step(15);
      chk("hold_active", 32'(active), 32'b01);
      chk("hold_ammo", 32'(ammo), 32'd2);
      chk("hold_y0", 32'(bulletY[6:0]), 32'd110);

      // Cooldown: edge 3 cycles after launch dropped, edge at 6 accepted
      fire = 1'b0; load_level = 1'b1;
      step(1);
      chk("lvl_ammo", 32'(ammo), 32'd3);
      chk("lvl_active", 32'(active), 32'd0);
      load_level = 1'b0;
      step(1);
      fire = 1'b1;
      step(1);
      chk("cd_launch0", 32'(active), 32'b01);
      fire = 1'b0;
      step(2);
      fire = 1'b1;
      step(1);
      chk("cd_drop_active", 32'(active), 32'b01);
      chk("cd_drop_ammo", 32'(ammo), 32'd2);
      fire = 1'b0;
      step(2);
      fire = 1'b1;
      step(1);
      chk("cd_fill_active", 32'(active), 32'b11);
      chk("cd_fill_ammo", 32'(ammo), 32'd1);
      chk("cd_fill_x1", 32'(bulletX[15:8]), 32'd81);
      chk("cd_fill_y1", 32'(bulletY[13:7]), 32'd115);

      // Pool full, then ammo exhaustion
      fire = 1'b0;
      step(6);
      fire = 1'b1;
      step(1);
      chk("full_active", 32'(active), 32'b11);
      chk("full_ammo", 32'(ammo), 32'd1);
      fire = 1'b0; hit = 2'b01;
      step(1);
      chk("free_hit_active", 32'(active), 32'b10);
      chk("free_hit_count", 32'(hit_count), 32'd1);
      hit = 2'b00; fire = 1'b1;
      step(1);
      chk("third_active", 32'(active), 32'b11);
      chk("third_ammo", 32'(ammo), 32'd0);
      fire = 1'b0; hit = 2'b11;
      step(1);
      chk("dual_hit_count", 32'(hit_count), 32'd3);
      chk("dual_hit_active", 32'(active), 32'd0);
      hit = 2'b00;
      step(5);
      fire = 1'b1;
      step(1);
      chk("empty_active", 32'(active), 32'd0);
      chk("empty_ammo", 32'(ammo), 32'd0);
      fire = 1'b0; load_level = 1'b1;
      step(1);
      chk("reload_ammo", 32'(ammo), 32'd3);
      chk("reload_active", 32'(active), 32'd0);
      chk("reload_hits", 32'(hit_count), 32'd0);
      load_level = 1'b0;

      // Hit on the same cycle as a step tick
      step(1);
      fire = 1'b1;
      step(1);
      chk("hp_launch", 32'(active), 32'b01);
      fire = 1'b0;
      step(3);
      chk("hp_pre_y0", 32'(bulletY[6:0]), 32'd115);
      hit = 2'b01;
      step(1);
      chk("hp_active", 32'(active), 32'd0);
      chk("hp_y0", 32'(bulletY[6:0]), 32'd115);
      chk("hp_move", 32'(move), 32'd0);
      chk("hp_count", 32'(hit_count), 32'd1);
      hit = 2'b00;
      step(1);
      chk("hp_parked_y0", 32'(bulletY[6:0]), 32'd116);
      hit = 2'b10;
      step(1);
      chk("idle_hit_count", 32'(hit_count), 32'd1);
      chk("idle_hit_active", 32'(active), 32'd0);
      hit = 2'b00;

      // Top edge
      playerY = 7'd1; fire = 1'b1;
      step(1);
      chk("top_launch_y0", 32'(bulletY[6:0]), 32'd1);
      chk("top_active", 32'(active), 32'b01);
      fire = 1'b0;
      step(4);
      chk("top_y0_zero", 32'(bulletY[6:0]), 32'd0);
      chk("top_move", 32'(move), 32'd1);
      step(4);
      chk("top_deact", 32'(active), 32'd0);
      chk("top_deact_move", 32'(move), 32'd0);
      chk("top_deact_y0", 32'(bulletY[6:0]), 32'd0);
      step(1);
      chk("top_park_y0", 32'(bulletY[6:0]), 32'd2);
      chk("top_park_x0", 32'(bulletX[7:0]), 32'd81);

      // Freeze
      load_level = 1'b1; playerY = 7'd50;
      step(1);
      load_level = 1'b0;
      step(1);
      fire = 1'b1;
      step(1);
      chk("frz_launch_y0", 32'(bulletY[6:0]), 32'd50);
      fire = 1'b0;
      step(2);
      play = 1'b0;
      step(4);
      fire = 1'b1;
      step(1);
      fire = 1'b0;
      step(5);
      chk("frz_active", 32'(active), 32'b01);
      chk("frz_ammo", 32'(ammo), 32'd2);
      chk("frz_y0", 32'(bulletY[6:0]), 32'd50);
      play = 1'b1;
      step(1);
      chk("resume_y0", 32'(bulletY[6:0]), 32'd50);
      chk("resume_move0", 32'(move), 32'd0);
      step(1);
      chk("resume_step_y0", 32'(bulletY[6:0]), 32'd49);
      chk("resume_move1", 32'(move), 32'd1);
      fire = 1'b1;
      step(1);
      chk("resume_cd_drop", 32'(active), 32'b01);
      fire = 1'b0;
      step(1);
      fire = 1'b1;
      step(1);
      chk("resume_cd_launch", 32'(active), 32'b11);
      chk("resume_cd_ammo", 32'(ammo), 32'd1);
      fire = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
